// File: rtl/dac_stream_pkg.sv
// rtl/dac_stream_pkg.sv - shared types, defaults and helpers for the DAC streaming stage
// Contents:
//   state_t        playback state (ST_IDLE / ST_RUN)
//   *_DEF          default parameter values for dac_stream_out
//   eff_div()      effective sample divider, max(div, 1)
package dac_stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int          FIFO_DEPTH_DEF = 64;
  localparam int          DIV_W_DEF      = 16;
  localparam logic [7:0]  IDLE_CODE_DEF  = 8'h80;

  // A divider of 0 would make every cycle a sample slot and leave no room
  // for a dac_clk low phase, so it is treated as 1.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/dac_stream_if.sv
// rtl/dac_stream_if.sv - sample push handshake between bus-side logic and the DAC stage
// Signals:
//   s_data   [7:0]  sample to push
//   s_valid         push request
//   s_ready         sink can accept (FIFO not full)
// Modports: master (sample source), slave (dac_stream_out)
interface dac_stream_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/dac_sample_fifo.sv
// rtl/dac_sample_fifo.sv - single-clock sample FIFO with occupancy output
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en, wr_data        write request/data (ignored while full)
//   rd_en                 pop request (ignored while empty)
//   rd_data               head-of-queue entry, valid while !empty
//   full, empty, level    status, level in 0..DEPTH
module dac_sample_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit: equal addresses with differing wrap
  // bits mean full, identical pointers mean empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_wr;
  logic do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dac_stream_out.sv
// rtl/dac_stream_out.sv - buffered, rate-controlled sample stream to a parallel DAC
// Build option: DAC_STREAM_TWOS_COMP_EN - samples are two's complement and are
//   converted to offset binary on push (MSB inverted); default passes them as-is.
// Ports:
//   hclk, hresetn   clock, asynchronous active-low reset
//   enable          playback enable (level)
//   div             sample period minus 1 in hclk cycles, 0 treated as 1
//   s               sample push handshake (dac_stream_if.slave)
//   fifo_level      FIFO occupancy
//   underrun        sticky: a sample slot found the FIFO empty
//   underrun_clr    pulse clearing underrun (a same-cycle set wins)
//   busy            enabled and FIFO non-empty or period in progress
//   dac_data        registered DAC code, IDLE_CODE while disabled
//   dac_clk         registered DAC clock, rises mid-sample
module dac_stream_out
  import dac_stream_pkg::*;
#(
  parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int         DIV_W      = DIV_W_DEF,
  parameter logic [7:0] IDLE_CODE  = IDLE_CODE_DEF
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              div,
  dac_stream_if.slave                   s,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic                          busy,
  output logic [7:0]                    dac_data,
  output logic                          dac_clk
);

  localparam logic [DIV_W:0] ONE_W = 1;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] eff_q, eff_d;
  logic [DIV_W:0]   half;
  logic [7:0]       dac_data_q, dac_data_d;
  logic             dac_clk_q, dac_clk_d;
  logic             underrun_q, underrun_d;
  logic             tick;
  logic             pop;
  logic             push;
  logic [7:0]       wr_data;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;

`ifdef DAC_STREAM_TWOS_COMP_EN
  assign wr_data = {~s.s_data[7], s.s_data[6:0]};
`else
  assign wr_data = s.s_data;
`endif

  assign s.s_ready = !fifo_full;
  assign push      = s.s_valid && !fifo_full;

  dac_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (hclk),
    .rst_n   (hresetn),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Emptiness is judged from registered state, so a sample pushed in a slot
  // cycle into an empty FIFO waits for the next slot.
  assign tick = enable && (cnt_q == eff_q);
  assign pop  = tick && !fifo_empty;

  always_comb begin
    state_d    = enable ? ST_RUN : ST_IDLE;
    cnt_d      = '0;
    eff_d      = eff_q;
    dac_data_d = dac_data_q;
    underrun_d = underrun_q;

    if (underrun_clr)       underrun_d = 1'b0;
    if (tick && fifo_empty) underrun_d = 1'b1;

    // The divider is latched only at a period boundary: while idle (which
    // also covers the first enabled cycle) and at each slot.
    if (state_q == ST_IDLE || tick) eff_d = DIV_W'(eff_div(32'(div)));

    if (!enable) begin
      dac_data_d = IDLE_CODE;
    end else begin
      if (!tick) cnt_d = cnt_q + DIV_W'(1);
      if (pop)   dac_data_d = fifo_rd_data;
    end

    // dac_clk is registered from the next count so it lines up with cnt:
    // low for the first half of the period, high from cnt == H onward.
    half      = ({1'b0, eff_d} + ONE_W) >> 1;
    dac_clk_d = enable && ({1'b0, cnt_d} >= half);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      eff_q      <= DIV_W'(1);
      dac_data_q <= IDLE_CODE;
      dac_clk_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      eff_q      <= eff_d;
      dac_data_q <= dac_data_d;
      dac_clk_q  <= dac_clk_d;
      underrun_q <= underrun_d;
    end
  end

  assign dac_data = dac_data_q;
  assign dac_clk  = dac_clk_q;
  assign underrun = underrun_q;
  assign busy     = enable && (!fifo_empty || (cnt_q != '0));

endmodule
